// File: rtl/booth_seq_if.sv
// Operand / result handshake bundle between booth_sequencer and its neighbours.
// The slave modport is the sequencer side; the master modport is the producer/consumer side.
interface booth_seq_if #(
    parameter int unsigned WIDTH_IN = 16,
    parameter int unsigned WIDTH_FP = 32
);
    logic                in_valid;
    logic                in_ready;
    logic [WIDTH_IN-1:0] in_a;
    logic [WIDTH_IN-1:0] in_b;
    logic                out_valid;
    logic                out_ready;
    logic [WIDTH_FP-1:0] out_product;

    modport slave (
        input  in_valid,
        input  in_a,
        input  in_b,
        input  out_ready,
        output in_ready,
        output out_valid,
        output out_product
    );

    modport master (
        output in_valid,
        output in_a,
        output in_b,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  out_product
    );
endinterface

// File: rtl/booth_sequencer.sv
// booth_sequencer: control/handshake stage in front of the Booth multiplier datapath.
// Accepts one operand pair, walks the datapath through LOAD/RUN/CAPTURE/SETTLE,
// then offers the captured product downstream. One multiply in flight at a time.
// Optional feature macro: BOOTH_SEQ_TIMEOUT_EN adds a RUN-cycle watchdog and the
// timeout_err_o port; without it RUN waits for count_i indefinitely.
module booth_sequencer #(
    parameter int unsigned WIDTH_IN = 16,
    parameter int unsigned WIDTH_FP = 32
`ifdef BOOTH_SEQ_TIMEOUT_EN
    , parameter int unsigned TIMEOUT_CYCLES = 24
`endif
) (
    input  logic                clk,
    input  logic                reset,
    booth_seq_if.slave          bus,
    output logic [WIDTH_IN-1:0] dp_multiplicand_a_o,
    output logic [WIDTH_IN-1:0] dp_multiplier_b_o,
    output logic                load_o,
    output logic                load_pp_o,
    output logic                load_p_o,
    output logic                enable_a_o,
    output logic                enable_b_o,
    output logic                enable_pp_o,
    input  logic                count_i,
    input  logic [WIDTH_FP-1:0] product_in_i,
    output logic                busy_o
`ifdef BOOTH_SEQ_TIMEOUT_EN
    , output logic              timeout_err_o
`endif
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_RUN,
        S_CAPTURE,
        S_SETTLE,
        S_DONE
    } state_e;

    state_e              state_q;
    logic                in_ready_q;
    logic                busy_q;
    logic                load_q;
    logic                load_pp_q;
    logic                load_p_q;
    logic                enable_a_q;
    logic                enable_b_q;
    logic                enable_pp_q;
    logic                out_valid_q;
    logic [WIDTH_IN-1:0] dp_a_q;
    logic [WIDTH_IN-1:0] dp_b_q;
    logic [WIDTH_FP-1:0] out_product_q;

`ifdef BOOTH_SEQ_TIMEOUT_EN
    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0] run_cnt_q;
    logic             timeout_err_q;
`endif

    // Sequencer FSM; strobes are registered alongside the state they belong to.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= S_IDLE;
            in_ready_q    <= 1'b0;
            busy_q        <= 1'b0;
            load_q        <= 1'b0;
            load_pp_q     <= 1'b0;
            load_p_q      <= 1'b0;
            enable_a_q    <= 1'b0;
            enable_b_q    <= 1'b0;
            enable_pp_q   <= 1'b0;
            out_valid_q   <= 1'b0;
            dp_a_q        <= '0;
            dp_b_q        <= '0;
            out_product_q <= '0;
`ifdef BOOTH_SEQ_TIMEOUT_EN
            run_cnt_q     <= '0;
            timeout_err_q <= 1'b0;
`endif
        end else begin
            load_q      <= 1'b0;
            load_pp_q   <= 1'b0;
            load_p_q    <= 1'b0;
            enable_a_q  <= 1'b0;
            enable_b_q  <= 1'b0;
            enable_pp_q <= 1'b0;
            out_valid_q <= 1'b0;

            case (state_q)
                S_IDLE: begin
                    in_ready_q <= 1'b1;
                    if (bus.in_valid && in_ready_q) begin
                        dp_a_q     <= bus.in_a;
                        dp_b_q     <= bus.in_b;
                        in_ready_q <= 1'b0;
                        busy_q     <= 1'b1;
                        load_q     <= 1'b1;
                        load_pp_q  <= 1'b1;
                        enable_a_q <= 1'b1;
                        enable_b_q <= 1'b1;
                        state_q    <= S_LOAD;
`ifdef BOOTH_SEQ_TIMEOUT_EN
                        timeout_err_q <= 1'b0;
`endif
                    end
                end
                S_LOAD: begin
                    enable_pp_q <= 1'b1;
                    state_q     <= S_RUN;
`ifdef BOOTH_SEQ_TIMEOUT_EN
                    run_cnt_q   <= '0;
`endif
                end
                S_RUN: begin
                    if (count_i) begin
                        load_p_q <= 1'b1;
                        state_q  <= S_CAPTURE;
`ifdef BOOTH_SEQ_TIMEOUT_EN
                    end else if (run_cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                        // datapath never signalled completion: abandon the multiply
                        timeout_err_q <= 1'b1;
                        busy_q        <= 1'b0;
                        in_ready_q    <= 1'b1;
                        state_q       <= S_IDLE;
                    end else begin
                        run_cnt_q   <= run_cnt_q + CNT_W'(1);
                        enable_pp_q <= 1'b1;
`else
                    end else begin
                        enable_pp_q <= 1'b1;
`endif
                    end
                end
                S_CAPTURE: begin
                    state_q <= S_SETTLE;
                end
                S_SETTLE: begin
                    out_product_q <= product_in_i;
                    out_valid_q   <= 1'b1;
                    state_q       <= S_DONE;
                end
                S_DONE: begin
                    if (bus.out_ready) begin
                        busy_q     <= 1'b0;
                        in_ready_q <= 1'b1;
                        state_q    <= S_IDLE;
                    end else begin
                        out_valid_q <= 1'b1;
                    end
                end
                default: begin
                    busy_q     <= 1'b0;
                    in_ready_q <= 1'b0;
                    state_q    <= S_IDLE;
                end
            endcase
        end
    end

    // Output drive from registered state.
    assign bus.in_ready        = in_ready_q;
    assign bus.out_valid       = out_valid_q;
    assign bus.out_product     = out_product_q;
    assign dp_multiplicand_a_o = dp_a_q;
    assign dp_multiplier_b_o   = dp_b_q;
    assign load_o              = load_q;
    assign load_pp_o           = load_pp_q;
    assign load_p_o            = load_p_q;
    assign enable_a_o          = enable_a_q;
    assign enable_b_o          = enable_b_q;
    assign enable_pp_o         = enable_pp_q;
    assign busy_o              = busy_q;
`ifdef BOOTH_SEQ_TIMEOUT_EN
    assign timeout_err_o       = timeout_err_q;
`endif

endmodule

// File: tb/tb_booth_sequencer.sv
// Testbench for booth_sequencer: randomized transactions checked every cycle against a
// timestamp-based transaction model, plus literal product expectations.
module tb_booth_sequencer;
    localparam int unsigned WI = 16;
    localparam int unsigned WF = 32;
    localparam int TO_CYC = 24;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    booth_seq_if #(.WIDTH_IN(WI), .WIDTH_FP(WF)) bus ();

    logic [WI-1:0] dp_a;
    logic [WI-1:0] dp_b;
    logic          load, load_pp, load_p, en_a, en_b, en_pp, count, busy;
    logic [WF-1:0] product_in;
`ifdef BOOTH_SEQ_TIMEOUT_EN
    logic          timeout_err;
`endif

    booth_sequencer #(.WIDTH_IN(WI), .WIDTH_FP(WF)) dut (
        .clk                 (clk),
        .reset               (reset),
        .bus                 (bus),
        .dp_multiplicand_a_o (dp_a),
        .dp_multiplier_b_o   (dp_b),
        .load_o              (load),
        .load_pp_o           (load_pp),
        .load_p_o            (load_p),
        .enable_a_o          (en_a),
        .enable_b_o          (en_b),
        .enable_pp_o         (en_pp),
        .count_i             (count),
        .product_in_i        (product_in),
        .busy_o              (busy)
`ifdef BOOTH_SEQ_TIMEOUT_EN
        , .timeout_err_o     (timeout_err)
`endif
    );

    function automatic logic [31:0] smul(input logic [15:0] a, input logic [15:0] b);
        longint x, y;
        x = longint'($signed(a));
        y = longint'($signed(b));
        return 32'(x * y);
    endfunction

    // Datapath stand-in: iteration counter with a per-transaction length, product on load_p.
    int unsigned   dp_cnt = 0;
    int unsigned   dp_target = 16;
    logic          noise = 1'b0;
    logic [WF-1:0] dp_prod = 32'hDEAD_BEEF;
    always @(posedge clk) begin
        if (load) dp_cnt <= 0;
        else if (en_pp) dp_cnt <= dp_cnt + 1;
        if (load_p) dp_prod <= smul(dp_a, dp_b);
    end
    assign count      = (dp_cnt == dp_target) || noise;
    assign product_in = dp_prod;

    // Transaction model: timestamps of accept / count sample / transfer.
    int          cyc = 0;
    bit          busy_m = 1'b0;
    int          t_acc = 0;
    int          t_k = -1;
    logic [15:0] ea = '0, eb = '0;
    logic [31:0] old_prod = '0, new_prod = '0;
    bit          terr_m = 1'b0;
    bit          xfer_flag = 1'b0;
    bit          abort_flag = 1'b0;

    logic        drv_iv = 1'b0, drv_ordy = 1'b0, drv_noise = 1'b0;
    logic [15:0] drv_a = '0, drv_b = '0;

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cyc=%0d actual=%h required=%h", name, cyc, act, exp);
        end
    endtask

    // One cycle: compare all outputs with the model, drive inputs, advance the model.
    task automatic tick();
        bit          e_load, e_pp, e_lp, e_ov;
        logic [31:0] e_prod;
        @(negedge clk);
        e_load = busy_m && (cyc == t_acc + 1);
        e_pp   = busy_m && (cyc >= t_acc + 2) && (t_k < 0);
        e_lp   = busy_m && (t_k >= 0) && (cyc == t_k + 1);
        e_ov   = busy_m && (t_k >= 0) && (cyc >= t_k + 3);
        e_prod = e_ov ? new_prod : old_prod;
        chk("in_ready",    bus.in_ready,    !busy_m);
        chk("busy",        busy,            busy_m);
        chk("load",        load,            e_load);
        chk("load_pp",     load_pp,         e_load);
        chk("enable_a",    en_a,            e_load);
        chk("enable_b",    en_b,            e_load);
        chk("enable_pp",   en_pp,           e_pp);
        chk("load_p",      load_p,          e_lp);
        chk("out_valid",   bus.out_valid,   e_ov);
        chk("out_product", bus.out_product, e_prod);
        chk("dp_a",        dp_a,            ea);
        chk("dp_b",        dp_b,            eb);
`ifdef BOOTH_SEQ_TIMEOUT_EN
        chk("timeout_err", timeout_err,     terr_m);
`endif
        bus.in_valid  = drv_iv;
        bus.in_a      = drv_a;
        bus.in_b      = drv_b;
        bus.out_ready = drv_ordy;
        noise         = drv_noise;
        #1;
        xfer_flag  = 1'b0;
        abort_flag = 1'b0;
        if (!busy_m) begin
            if (drv_iv) begin
                busy_m   = 1'b1;
                t_acc    = cyc;
                t_k      = -1;
                ea       = drv_a;
                eb       = drv_b;
                new_prod = smul(drv_a, drv_b);
                terr_m   = 1'b0;
            end
        end else if (t_k < 0) begin
            if (cyc >= t_acc + 2) begin
                if (count === 1'b1) t_k = cyc;
`ifdef BOOTH_SEQ_TIMEOUT_EN
                else if (cyc == t_acc + 1 + TO_CYC) begin
                    busy_m     = 1'b0;
                    terr_m     = 1'b1;
                    abort_flag = 1'b1;
                end
`endif
            end
        end else if (cyc >= t_k + 3 && drv_ordy) begin
            busy_m    = 1'b0;
            old_prod  = new_prod;
            xfer_flag = 1'b1;
        end
        cyc++;
    endtask

    // Full transaction; hold = DONE cycles with out_ready low before release.
    task automatic txn(input logic [15:0] a, input logic [15:0] b, input int hold,
                       input bit lit_en, input logic [31:0] lit, input bit inject);
        int  done_cnt;
        bit  seen;
        bit  in_done;
        dp_target = $urandom_range(0, 20);
        drv_iv    = 1'b1;
        drv_a     = a;
        drv_b     = b;
        drv_ordy  = 1'b0;
        drv_noise = ($urandom_range(0, 7) == 0);
        tick();
        done_cnt = 0;
        seen     = 1'b0;
        for (int g = 0; g < 300 && !seen && busy_m; g++) begin
            drv_iv    = inject ? 1'($urandom_range(0, 1)) : 1'b0;
            drv_a     = 16'($urandom);
            drv_b     = 16'($urandom);
            in_done   = (t_k >= 0) && (cyc >= t_k + 3);
            drv_ordy  = in_done ? (done_cnt >= hold) : 1'($urandom_range(0, 1));
            drv_noise = ($urandom_range(0, 7) == 0);
            tick();
            if (in_done) done_cnt++;
            if (xfer_flag) begin
                seen = 1'b1;
                if (lit_en) chk("literal_product", bus.out_product, lit);
            end
        end
        chk("txn_complete", seen, 1'b1);
        drv_iv    = 1'b0;
        drv_ordy  = 1'b0;
        drv_noise = 1'b0;
    endtask

    initial begin
        bus.in_valid  = 1'b0;
        bus.in_a      = '0;
        bus.in_b      = '0;
        bus.out_ready = 1'b0;

        // reset state
        #12;
        chk("rst_in_ready",  bus.in_ready,    1'b0);
        chk("rst_out_valid", bus.out_valid,   1'b0);
        chk("rst_busy",      busy,            1'b0);
        chk("rst_load",      load,            1'b0);
        chk("rst_enable_pp", en_pp,           1'b0);
        chk("rst_product",   bus.out_product, 32'h0);
        chk("rst_dp_a",      dp_a,            16'h0);
        @(negedge clk);
        reset = 1'b0;
        tick();
        tick();

        // directed products with literal expectations; out_ready high on first DONE cycle
        txn(16'd3,    16'd5,    0, 1'b1, 32'h0000_000F, 1'b0);
        txn(16'hFFFE, 16'd7,    0, 1'b1, 32'hFFFF_FFF2, 1'b0);
        txn(16'h8000, 16'h8000, 0, 1'b1, 32'h4000_0000, 1'b0);
        txn(16'h7FFF, 16'h8000, 2, 1'b1, 32'hC000_8000, 1'b0);
        // back-pressure in DONE for 10 cycles
        txn(16'h1234, 16'h5678, 10, 1'b1, 32'h0626_0060, 1'b0);
        // new operands offered while busy must be ignored
        txn(16'hFFFF, 16'hFFFF, 1, 1'b1, 32'h0000_0001, 1'b1);

        // reset asserted in RUN
        dp_target = 16;
        drv_iv    = 1'b1;
        drv_a     = 16'd100;
        drv_b     = 16'd200;
        drv_noise = 1'b0;
        tick();
        drv_iv = 1'b0;
        repeat (5) tick();
        reset = 1'b1;
        #1;
        chk("midrst_enable_pp", en_pp,         1'b0);
        chk("midrst_load_p",    load_p,        1'b0);
        chk("midrst_out_valid", bus.out_valid, 1'b0);
        chk("midrst_busy",      busy,          1'b0);
        chk("midrst_product",   bus.out_product, 32'h0);
        @(negedge clk);
        reset    = 1'b0;
        busy_m   = 1'b0;
        t_k      = -1;
        old_prod = '0;
        ea       = '0;
        eb       = '0;
        terr_m   = 1'b0;
        tick();
        txn(16'hFFF6, 16'd25, 0, 1'b1, 32'hFFFF_FF06, 1'b0);

        // randomized traffic
        for (int i = 0; i < 30; i++) begin
            txn(16'($urandom), 16'($urandom), $urandom_range(0, 3), 1'b0, 32'h0,
                1'($urandom_range(0, 1)));
            repeat ($urandom_range(0, 2)) tick();
        end

`ifdef BOOTH_SEQ_TIMEOUT_EN
        // datapath never completes: watchdog abort, then a clean transaction clears the flag
        begin
            bit aborted;
            aborted   = 1'b0;
            dp_target = 32'hFFFF_FFFF;
            drv_iv    = 1'b1;
            drv_a     = 16'd9;
            drv_b     = 16'd9;
            drv_noise = 1'b0;
            tick();
            drv_iv = 1'b0;
            for (int g = 0; g < 60 && busy_m; g++) begin
                tick();
                if (abort_flag) aborted = 1'b1;
            end
            chk("timeout_abort", aborted, 1'b1);
            tick();
            chk("timeout_err_set", timeout_err, 1'b1);
            txn(16'd6, 16'd7, 0, 1'b1, 32'h0000_002A, 1'b0);
        end
`endif

        tick();
        tick();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
